// File: rtl/eth_svc_if.sv
// Byte-stream bundle between the MAC interface layer and the service dispatcher.
// RX has no backpressure; TX transfers a byte when tx_valid && tx_ready, and the
// source holds tx_valid/tx_data/tx_last stable until that happens.
interface eth_svc_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_last;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;

    modport master (
        output rx_valid, rx_data, rx_last, tx_ready,
        input  tx_valid, tx_data, tx_last
    );

    modport slave (
        input  rx_valid, rx_data, rx_last, tx_ready,
        output tx_valid, tx_data, tx_last
    );
endinterface

// File: rtl/eth_svc_dispatch.sv
// Buffers one frame, filters on destination MAC and service ethertype, echoes
// matches with MACs swapped. Frame counters are enabled by ETH_SVC_STATS_EN.
module eth_svc_dispatch #(
    parameter int                    MAX_LEN    = 1514,
    parameter int                    NUM_SVC    = 2,
    parameter logic [NUM_SVC*16-1:0] SVC_ETYPES = {16'h1235, 16'h1234},
    parameter logic [47:0]           MY_MAC     = 48'hb827eba43073
) (
    input  logic        clk,
    input  logic        rst,
    eth_svc_if.slave    bus,
    output logic [1:0]  svc_id,
    output logic        busy,
    output logic [15:0] pkt_echoed,
    output logic [15:0] pkt_dropped,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int CW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        RECV    = 2'd0,
        DISCARD = 2'd1,
        SEND    = 2'd2
    } state_t;

    state_t         state;
    logic [7:0]     mem [MAX_LEN];
    logic [CW-1:0]  wr_cnt;
    logic [CW-1:0]  rd_ptr;
    logic [CW-1:0]  last_idx;
    logic [CW-1:0]  rd_addr_full;
    logic [AW-1:0]  rd_addr;
    logic           tx_valid_q;
    logic [7:0]     tx_data_q;
    logic           tx_last_q;
    logic [1:0]     svc_q;
    logic           dst_mine;
    logic           dst_bcast;
    logic           etype_hit;
    logic [1:0]     etype_sel;
    logic [7:0]     etype_hi;
    logic           skip_pend;
    logic           drop_at_end;
    logic           mine_nx;
    logic           bcast_nx;
    logic           hit_nx;
    logic [1:0]     sel_nx;
    logic           frame_ok;
    logic           skip_open;
    logic           echo_evt;
    logic           drop_evt;

    function automatic logic [7:0] mac_byte(input int i);
        logic [47:0] t;
        t = MY_MAC << (8 * i);
        return t[47:40];
    endfunction

    // Header checks resolve on the byte being accepted so rx_last on byte 13 decides correctly.
    always_comb begin
        mine_nx  = dst_mine;
        bcast_nx = dst_bcast;
        hit_nx   = etype_hit;
        sel_nx   = etype_sel;
        if (wr_cnt == '0) begin
            mine_nx  = 1'b1;
            bcast_nx = 1'b1;
            hit_nx   = 1'b0;
            sel_nx   = 2'd0;
        end
        if (wr_cnt < CW'(6)) begin
            mine_nx  = mine_nx && (bus.rx_data == mac_byte(int'(wr_cnt)));
            bcast_nx = bcast_nx && (bus.rx_data == 8'hff);
        end
        if (wr_cnt == CW'(13)) begin
            for (int k = NUM_SVC - 1; k >= 0; k--) begin
                if ({etype_hi, bus.rx_data} == SVC_ETYPES[16*k +: 16]) begin
                    hit_nx = 1'b1;
                    sel_nx = 2'(k);
                end
            end
        end
        frame_ok  = (mine_nx || bcast_nx) && hit_nx &&
                    (wr_cnt >= CW'(13)) && (wr_cnt < CW'(MAX_LEN));
        skip_open = bus.rx_valid ? !bus.rx_last : skip_pend;
    end

    always_comb begin
        echo_evt = 1'b0;
        drop_evt = 1'b0;
        case (state)
            RECV: begin
                if (bus.rx_valid)
                    drop_evt = bus.rx_last ? !frame_ok : (wr_cnt == CW'(MAX_LEN));
            end
            SEND: begin
                echo_evt = tx_valid_q && bus.tx_ready && tx_last_q;
                drop_evt = bus.rx_valid && bus.rx_last;
            end
            DISCARD: drop_evt = bus.rx_valid && bus.rx_last && drop_at_end;
            default: ;
        endcase
    end

    // Output bytes 0-5 come from stored bytes 6-11 (old source becomes destination).
    assign rd_addr_full = (rd_ptr < CW'(6)) ? rd_ptr + CW'(6) : rd_ptr;
    assign rd_addr      = rd_addr_full[AW-1:0];

    always_ff @(posedge clk) begin
        if (state == RECV && bus.rx_valid && wr_cnt < CW'(MAX_LEN))
            mem[wr_cnt[AW-1:0]] <= bus.rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RECV;
            wr_cnt      <= '0;
            rd_ptr      <= '0;
            last_idx    <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_last_q   <= 1'b0;
            svc_q       <= 2'd0;
            dst_mine    <= 1'b0;
            dst_bcast   <= 1'b0;
            etype_hit   <= 1'b0;
            etype_sel   <= 2'd0;
            etype_hi    <= 8'h00;
            skip_pend   <= 1'b0;
            drop_at_end <= 1'b0;
        end else begin
            case (state)
                RECV: begin
                    if (bus.rx_valid) begin
                        dst_mine  <= mine_nx;
                        dst_bcast <= bcast_nx;
                        etype_hit <= hit_nx;
                        etype_sel <= sel_nx;
                        if (wr_cnt == CW'(12))
                            etype_hi <= bus.rx_data;
                        if (bus.rx_last) begin
                            wr_cnt <= '0;
                            if (frame_ok) begin
                                state    <= SEND;
                                svc_q    <= sel_nx;
                                last_idx <= wr_cnt;
                                rd_ptr   <= '0;
                            end
                        end else if (drop_evt) begin
                            state       <= DISCARD;
                            drop_at_end <= 1'b0;
                            wr_cnt      <= '0;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                DISCARD: begin
                    if (bus.rx_valid && bus.rx_last) begin
                        state       <= RECV;
                        drop_at_end <= 1'b0;
                    end
                end
                SEND: begin
                    // Frames arriving while echoing are never stored; finish skipping one in DISCARD.
                    if (bus.rx_valid)
                        skip_pend <= !bus.rx_last;
                    if (echo_evt) begin
                        tx_valid_q  <= 1'b0;
                        tx_last_q   <= 1'b0;
                        rd_ptr      <= '0;
                        wr_cnt      <= '0;
                        skip_pend   <= 1'b0;
                        drop_at_end <= skip_open;
                        state       <= skip_open ? DISCARD : RECV;
                    end else if (!tx_valid_q || bus.tx_ready) begin
                        if (rd_ptr <= last_idx) begin
                            tx_valid_q <= 1'b1;
                            tx_last_q  <= (rd_ptr == last_idx);
                            if (rd_ptr >= CW'(6) && rd_ptr < CW'(12))
                                tx_data_q <= mac_byte(int'(rd_ptr) - 6);
                            else
                                tx_data_q <= mem[rd_addr];
                            rd_ptr <= rd_ptr + 1'b1;
                        end else begin
                            tx_valid_q <= 1'b0;
                        end
                    end
                end
                default: state <= RECV;
            endcase
        end
    end

    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_last  = tx_last_q;
    assign svc_id       = svc_q;
    assign busy         = (state != RECV);
    assign dbg_state    = state;

`ifdef ETH_SVC_STATS_EN
    logic [15:0] echo_cnt;
    logic [15:0] drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            echo_cnt <= 16'h0000;
            drop_cnt <= 16'h0000;
        end else begin
            if (echo_evt && echo_cnt != 16'hffff)
                echo_cnt <= echo_cnt + 16'h0001;
            if (drop_evt && drop_cnt != 16'hffff)
                drop_cnt <= drop_cnt + 16'h0001;
        end
    end

    assign pkt_echoed  = echo_cnt;
    assign pkt_dropped = drop_cnt;
`else
    assign pkt_echoed  = 16'h0000;
    assign pkt_dropped = 16'h0000;
`endif

endmodule
